// File: rtl/tinyflash_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tinyflash_pkg : default sizes and thermometer-to-binary encoder  (Rev 1.0)
// ============================================================================
package tinyflash_pkg;

  localparam int N_BITS_DEF   = 3;
  localparam int AVG_LOG2_DEF = 2;
  localparam int DIV_W_DEF    = 8;

  // Widest comparator bank the encoder handles (N_BITS up to 8).
  localparam int MAX_T        = 255;

  // Index of the highest set bit plus one, or 0 when no bit is set.
  function automatic logic [7:0] therm_encode(input logic [MAX_T-1:0] t);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < MAX_T; i++) begin
      if (t[i]) s = 8'(i + 1);
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tinyflash_therm_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tinyflash_therm_enc : optional bubble fix (TINYFLASH_BUBBLE_FIX_EN) + encode
// Rev 1.0
// ============================================================================
module tinyflash_therm_enc
  import tinyflash_pkg::*;
#(
  parameter  int N_BITS = N_BITS_DEF,
  localparam int T      = (2**N_BITS) - 1
) (
  input  logic [T-1:0]      therm,
  output logic [N_BITS-1:0] s
);

  logic [T-1:0]     fixed;
  logic [MAX_T-1:0] padded;

`ifdef TINYFLASH_BUBBLE_FIX_EN
  // Bank extended with an implied always-on bit below and always-off bit above.
  logic [T+1:0] ext;
  assign ext = {1'b0, therm, 1'b1};

  for (genvar i = 0; i < T; i++) begin : g_bubble
    assign fixed[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
  end
`else
  assign fixed = therm;
`endif

  always_comb begin
    padded        = '0;
    padded[T-1:0] = fixed;
  end

  assign s = N_BITS'(therm_encode(padded));

endmodule

`default_nettype wire

// File: rtl/tinyflash_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tinyflash_sampler : flash-ADC back end - sync, rate divide, encode, average,
// valid/ready output with sticky overrun. Bubble fix: TINYFLASH_BUBBLE_FIX_EN.
// Rev 1.0
// ============================================================================
module tinyflash_sampler
  import tinyflash_pkg::*;
#(
  parameter  int N_BITS   = N_BITS_DEF,
  parameter  int AVG_LOG2 = AVG_LOG2_DEF,
  parameter  int DIV_W    = DIV_W_DEF,
  localparam int T        = (2**N_BITS) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DIV_W-1:0]  div,
  input  logic [T-1:0]      therm_in,
  output logic [N_BITS-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int ACC_W  = N_BITS + AVG_LOG2;
  localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((2**AVG_LOG2) - 1);

  logic [T-1:0]      sync1;
  logic [T-1:0]      sync2;
  logic [DIV_W-1:0]  cnt;
  logic [SCNT_W-1:0] scnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [N_BITS-1:0] s;
  logic [N_BITS-1:0] result;
  logic              strobe;
  logic              last;
  logic              new_result;
  logic              load_ok;

  // Comparator bank is asynchronous; the synchroniser ignores ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= therm_in;
      sync2 <= sync1;
    end
  end

  tinyflash_therm_enc #(
    .N_BITS (N_BITS)
  ) u_enc (
    .therm (sync2),
    .s     (s)
  );

  // >= rather than == so a lowered div takes effect without wrapping.
  assign strobe     = ena && (cnt >= div);
  assign last       = (scnt == SCNT_LAST);
  assign new_result = strobe && last;
  assign acc_sum    = acc + ACC_W'(s);
  assign result     = acc_sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      scnt <= '0;
      acc  <= '0;
    end else if (ena) begin
      if (strobe) begin
        cnt <= '0;
        if (last) begin
          scnt <= '0;
          acc  <= '0;
        end else begin
          scnt <= scnt + SCNT_W'(1);
          acc  <= acc_sum;
        end
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  // code_ready reaches only this load enable, keeping outputs pure flops.
  assign load_ok = !code_valid || code_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (new_result && load_ok) begin
        code       <= result;
        code_valid <= 1'b1;
      end else if (code_valid && code_ready) begin
        code_valid <= 1'b0;
      end

      if (new_result && !load_ok) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tinyflash_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// tb_tinyflash_sampler : scoreboard bench for tinyflash_sampler at default sizes.
module tb_tinyflash_sampler;

  localparam int N_BITS = 3;
  localparam int DIV_W  = 8;
  localparam int T      = 7;

  logic              clk         = 1'b0;
  logic              rst_n       = 1'b0;
  logic              ena         = 1'b0;
  logic [DIV_W-1:0]  div         = '0;
  logic [T-1:0]      therm_in    = '0;
  logic              code_ready  = 1'b0;
  logic              clr_overrun = 1'b0;
  logic [N_BITS-1:0] code;
  logic              code_valid;
  logic              overrun;

  int passed = 0;
  int total  = 0;

  logic [N_BITS-1:0] sb[$];
  logic [N_BITS-1:0] sb_exp;

  always #5 clk = ~clk;

  tinyflash_sampler #(
    .N_BITS   (3),
    .AVG_LOG2 (2),
    .DIV_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .div         (div),
    .therm_in    (therm_in),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // Every transfer (valid & ready ahead of the next edge) pops one expected code.
  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got transfer of code=%0d, required no transfer", code);
      end else begin
        sb_exp = sb.pop_front();
        if (code !== sb_exp)
          $display("FAIL sb_code: got code=%0d, required %0d", code, sb_exp);
        else
          passed++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Releases reset 2 ns after a rising edge; tick counts start from there.
  task automatic hold_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; therm_in = 7'b0000111; div = 8'd3; ena = 1'b1; code_ready = 1'b1;
    repeat (3) tick();
    total++; if (code !== 3'd0) $display("FAIL reset_code: got %0d, required 0", code); else passed++;
    total++; if (code_valid !== 1'b0) $display("FAIL reset_valid: got %0b, required 0", code_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b, required 0", overrun); else passed++;
  endtask

  task automatic test_basic();
    int first, second;
    therm_in = 7'b0000111; div = 8'd3; ena = 1'b1; code_ready = 1'b1; clr_overrun = 1'b0;
    hold_reset();
    sb.push_back(3'd3); sb.push_back(3'd3);
    first = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (code_valid) begin first = n; break; end
    end
    // The release cycle itself counts as cycle 1.
    total++;
    if (first + 1 < 17 || first + 1 > 19)
      $display("FAIL basic_latency: got %0d cycles, required 17..19", first + 1);
    else passed++;
    tick();
    total++; if (code_valid !== 1'b0) $display("FAIL basic_pulse: got valid=%0b, required 0", code_valid); else passed++;
    second = 0;
    for (int n = first + 2; n <= first + 60; n++) begin
      tick();
      if (code_valid) begin second = n; break; end
    end
    total++; if (second - first != 16) $display("FAIL basic_period: got %0d, required 16", second - first); else passed++;
    tick();
    total++; if (sb.size() != 0) $display("FAIL basic_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  task automatic test_trunc();
    therm_in = 7'b0000001; div = 8'd3; ena = 1'b1; code_ready = 1'b1;
    hold_reset();
    sb.push_back(3'd1);  // (1+2+1+2) >> 2
    for (int k = 0; k < 4; k++) begin
      repeat (4) tick();
      therm_in = (k % 2 == 0) ? 7'b0000011 : 7'b0000001;
    end
    total++; if (code_valid !== 1'b1) $display("FAIL trunc_valid: got %0b, required 1", code_valid); else passed++;
    total++; if (code !== 3'd1) $display("FAIL trunc_code: got %0d, required 1", code); else passed++;
    tick();
    total++; if (sb.size() != 0) $display("FAIL trunc_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  task automatic test_overrun();
    therm_in = 7'b0000111; div = 8'd3; ena = 1'b1; code_ready = 1'b0; clr_overrun = 1'b0;
    hold_reset();
    repeat (17) tick();
    therm_in = 7'b0011111;
    total++; if (code_valid !== 1'b1 || code !== 3'd3)
      $display("FAIL ovr_first: got valid=%0b code=%0d, required 1/3", code_valid, code); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %0b, required 0", overrun); else passed++;
    repeat (17) tick();
    total++; if (code !== 3'd3) $display("FAIL ovr_held: got %0d, required 3", code); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0b, required 1", overrun); else passed++;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %0b, required 0", overrun); else passed++;
    sb.push_back(3'd3);
    code_ready = 1'b1;
    tick(); tick();
    total++; if (code_valid !== 1'b0) $display("FAIL ovr_consumed: got valid=%0b, required 0", code_valid); else passed++;
    total++; if (sb.size() != 0) $display("FAIL ovr_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  task automatic test_bubble();
    logic [N_BITS-1:0] exp_code;
`ifdef TINYFLASH_BUBBLE_FIX_EN
    exp_code = 3'd3;  // bit 2 bubble filled, bit 3 outlier removed
`else
    exp_code = 3'd4;  // highest set bit is bit 3
`endif
    therm_in = 7'b0001011; div = 8'd0; ena = 1'b0; code_ready = 1'b1;
    hold_reset();
    repeat (3) tick();  // let the synchroniser fill before sampling
    ena = 1'b1;
    sb.push_back(exp_code); sb.push_back(exp_code);
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    total++; if (sb.size() != 0) $display("FAIL bubble_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  task automatic test_ena();
    int first;
    therm_in = 7'b0000111; div = 8'd3; ena = 1'b1; code_ready = 1'b1;
    hold_reset();
    sb.push_back(3'd3);
    repeat (6) tick();
    ena = 1'b0;
    repeat (20) tick();
    ena = 1'b1;
    first = 0;
    for (int n = 27; n <= 80; n++) begin
      tick();
      if (code_valid) begin first = n; break; end
    end
    total++; if (first != 36) $display("FAIL ena_stretch: got tick %0d, required 36", first); else passed++;
    tick();
    total++; if (sb.size() != 0) $display("FAIL ena_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first;
    therm_in = 7'b0000111; div = 8'd3; ena = 1'b1; code_ready = 1'b0;
    hold_reset();
    repeat (22) tick();
    total++; if (code_valid !== 1'b1) $display("FAIL rmid_pre: got valid=%0b, required 1", code_valid); else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    therm_in = 7'b0011111;
    #1;
    total++; if (code !== 3'd0) $display("FAIL rmid_code: got %0d, required 0", code); else passed++;
    total++; if (code_valid !== 1'b0) $display("FAIL rmid_valid: got %0b, required 0", code_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rmid_overrun: got %0b, required 0", overrun); else passed++;
    tick();
    rst_n = 1'b1;
    code_ready = 1'b1;
    sb.push_back(3'd5);
    first = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (code_valid) begin first = n; break; end
    end
    total++; if (first != 16) $display("FAIL rmid_restart: got tick %0d, required 16", first); else passed++;
    tick();
    total++; if (sb.size() != 0) $display("FAIL rmid_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  task automatic test_back_to_back();
    therm_in = 7'b0000111; div = 8'd3; ena = 1'b1; code_ready = 1'b0;
    hold_reset();
    sb.push_back(3'd3); sb.push_back(3'd5);
    repeat (17) tick();
    therm_in = 7'b0011111;
    repeat (14) tick();
    total++; if (code_valid !== 1'b1 || code !== 3'd3)
      $display("FAIL b2b_held: got valid=%0b code=%0d, required 1/3", code_valid, code); else passed++;
    code_ready = 1'b1;
    tick();
    total++; if (code_valid !== 1'b1) $display("FAIL b2b_valid: got %0b, required 1", code_valid); else passed++;
    total++; if (code !== 3'd5) $display("FAIL b2b_code: got %0d, required 5", code); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %0b, required 0", overrun); else passed++;
    tick();
    total++; if (code_valid !== 1'b0) $display("FAIL b2b_fall: got %0b, required 0", code_valid); else passed++;
    total++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d left, required 0", sb.size()); else passed++;
    ena = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_overrun();
    test_bubble();
    test_ena();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (sb.size() != 0) $display("FAIL sb_final: got %0d left, required 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
